// File: rtl/fetch_pkg.sv
// Shared types and sizing for the fetch stage.
// FETCH_PREFETCH_EN selects a two-entry buffer; otherwise a single entry is used.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 8;
  localparam int unsigned FETCH_INSTR_W = 9;

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned FETCH_DEPTH = 2;
`else
  localparam int unsigned FETCH_DEPTH = 1;
`endif

  localparam int unsigned FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StIdle  = 2'd0;
  localparam fetch_state_t StFetch = 2'd1;
  localparam fetch_state_t StStall = 2'd2;
  localparam fetch_state_t StFlush = 2'd3;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {instr, pc} entries with flush.
// Push and pop may coincide at any occupancy, including full.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues imem reads at pc, buffers returns, drives PC step/redirect.
// Buffer depth comes from fetch_pkg (FETCH_PREFETCH_EN selects two entries).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_advance,
  output logic [ADDR_W-1:0]  pc_control,
  output logic [ADDR_W-1:0]  jump_offset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_offset,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  fetch_state_t state_q, state_d;
  logic                   inflight_q;
  logic [ADDR_W-1:0]      req_pc_q;
  logic [ADDR_W-1:0]      offset_q;
  logic                   in_flush, credit, request, pop, push;
  logic [31:0]            demand;
  fetch_entry_t           push_entry, head;
  logic                   buf_full, buf_empty;
  logic [FETCH_CNT_W-1:0] buf_count;

  assign in_flush    = (state_q == StFlush);
  assign instr_valid = !buf_empty && !in_flush;
  assign pop         = instr_valid && instr_ready;

  // Credit counts the word still in flight so the buffer can never overflow.
  always_comb begin
    demand  = 32'(buf_count) + 32'(inflight_q) - 32'(pop);
    credit  = (demand < 32'(FETCH_DEPTH));
    request = ((state_q == StFetch) || (state_q == StStall)) && credit;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:           state_d = StFetch;
      StFetch, StStall: state_d = br_taken ? StFlush : (credit ? StFetch : StStall);
      StFlush:          state_d = br_taken ? StFlush : StFetch;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      offset_q   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= request;
      if (request) req_pc_q <= pc;
      if (br_taken && (state_q != StIdle)) offset_q <= br_offset;
    end
  end

  // A response landing during the flush cycle belongs to the old path.
  assign push             = inflight_q && !in_flush && (!buf_full || pop);
  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = req_pc_q;

  fetch_buffer #(
    .DEPTH (FETCH_DEPTH),
    .CNT_W (FETCH_CNT_W)
  ) u_fetch_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (in_flush),
    .head      (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign pc_advance  = request || in_flush;
  assign pc_control  = in_flush ? {ADDR_W{1'b1}} : '0;
  assign jump_offset = in_flush ? offset_q : '0;
  assign imem_en     = request;
  assign imem_addr   = request ? pc : '0;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a program_counter and imem stand-in.
module tb_instruction_fetch;

`ifdef FETCH_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] pc;
  logic       pc_advance;
  logic [7:0] pc_control;
  logic [7:0] jump_offset;
  logic       imem_en;
  logic [7:0] imem_addr;
  logic [8:0] imem_rdata;
  logic       br_taken;
  logic [7:0] br_offset;
  logic [8:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;

  int total = 0;
  int bad   = 0;
  bit found;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .pc_control  (pc_control),
    .jump_offset (jump_offset),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream program counter and a memory returning {1, addr} one cycle later.
  always @(posedge clk) begin
    if (reset) pc <= 8'h00;
    else if (pc_advance) pc <= pc + 8'h01 + (pc_control & jump_offset);
  end

  always @(posedge clk) imem_rdata <= imem_en ? {1'b1, imem_addr} : 9'h000;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic bt, input logic [7:0] off);
    @(posedge clk);
    #1;
    reset       = r;
    instr_ready = rdy;
    br_taken    = bt;
    br_offset   = off;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; instr_ready = 1'b0; br_taken = 1'b0; br_offset = 8'h00;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_pc_advance", 16'(pc_advance), 16'h0);
    check("rst_pc_control", 16'(pc_control), 16'h0);
    check("rst_jump_offset", 16'(jump_offset), 16'h0);
    check("rst_imem_en", 16'(imem_en), 16'h0);
    check("rst_imem_addr", 16'(imem_addr), 16'h0);
    check("rst_instr", 16'(instr), 16'h0);
    check("rst_instr_pc", 16'(instr_pc), 16'h0);
    check("rst_instr_valid", 16'(instr_valid), 16'h0);

    // Streaming from pc 0 with decode always ready.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 0, IDLE
    check("c0_imem_en", 16'(imem_en), 16'h0);
    check("c0_pc_advance", 16'(pc_advance), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 1
    check("c1_imem_en", 16'(imem_en), 16'h1);
    check("c1_imem_addr", 16'(imem_addr), 16'h00);
    check("c1_pc_advance", 16'(pc_advance), 16'h1);
    check("c1_valid", 16'(instr_valid), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 2
    check("c2_imem_en", 16'(imem_en), PF ? 16'h1 : 16'h0);
    check("c2_imem_addr", 16'(imem_addr), PF ? 16'h01 : 16'h00);
    check("c2_pc_advance", 16'(pc_advance), PF ? 16'h1 : 16'h0);
    check("c2_valid", 16'(instr_valid), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 3
    check("c3_valid", 16'(instr_valid), 16'h1);
    check("c3_instr_pc", 16'(instr_pc), 16'h00);
    check("c3_instr", 16'(instr), 16'h100);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 4
    check("c4_valid", 16'(instr_valid), PF ? 16'h1 : 16'h0);
    check("c4_instr_pc", 16'(instr_pc), PF ? 16'h01 : 16'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 5
    check("c5_valid", 16'(instr_valid), 16'h1);
    check("c5_instr_pc", 16'(instr_pc), PF ? 16'h02 : 16'h01);
    check("c5_instr", 16'(instr), PF ? 16'h102 : 16'h101);

    // Back-pressure: buffer fills, fetch stalls, pc freezes.
    cyc(1'b0, 1'b0, 1'b0, 8'h00);  // cycle 6
    cyc(1'b0, 1'b0, 1'b0, 8'h00);  // cycle 7
    check("c7_imem_en", 16'(imem_en), 16'h0);
    check("c7_pc_advance", 16'(pc_advance), 16'h0);
    check("c7_valid", 16'(instr_valid), 16'h1);
    check("c7_instr_pc", 16'(instr_pc), PF ? 16'h03 : 16'h02);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);  // cycle 8
    cyc(1'b0, 1'b0, 1'b0, 8'h00);  // cycle 9
    check("c9_pc_frozen", 16'(pc), PF ? 16'h05 : 16'h03);
    check("c9_imem_en", 16'(imem_en), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 10, release
    check("c10_imem_en", 16'(imem_en), 16'h1);
    check("c10_imem_addr", 16'(imem_addr), PF ? 16'h05 : 16'h03);
    check("c10_instr_pc", 16'(instr_pc), PF ? 16'h03 : 16'h02);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 11
    check("c11_valid", 16'(instr_valid), PF ? 16'h1 : 16'h0);
    check("c11_instr_pc", 16'(instr_pc), PF ? 16'h04 : 16'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 12
    check("c12_valid", 16'(instr_valid), 16'h1);
    check("c12_instr_pc", 16'(instr_pc), PF ? 16'h05 : 16'h03);

    // Redirect: branch raised in the cycle fetching 0x0F, FLUSH sees pc 0x10.
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      if (pc == 8'h0F && imem_en) begin
        found = 1'b1;
        break;
      end
    end
    check("branch_point_found", 16'(found), 16'h1);
    br_taken  = 1'b1;
    br_offset = 8'h05;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // FLUSH
    check("fl_pc", 16'(pc), 16'h10);
    check("fl_pc_control", 16'(pc_control), 16'hFF);
    check("fl_jump_offset", 16'(jump_offset), 16'h05);
    check("fl_pc_advance", 16'(pc_advance), 16'h1);
    check("fl_imem_en", 16'(imem_en), 16'h0);
    check("fl_valid", 16'(instr_valid), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("fl2_imem_en", 16'(imem_en), 16'h1);
    check("fl2_imem_addr", 16'(imem_addr), 16'h16);
    check("fl2_pc_control", 16'(pc_control), 16'h00);
    check("fl2_valid", 16'(instr_valid), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("fl3_valid", 16'(instr_valid), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("fl4_valid", 16'(instr_valid), 16'h1);
    check("fl4_instr_pc", 16'(instr_pc), 16'h16);
    check("fl4_instr", 16'(instr), 16'h116);

    // Fill the buffer, then reset together with a branch.
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    check("full_valid", 16'(instr_valid), 16'h1);
    cyc(1'b1, 1'b0, 1'b1, 8'h22);
    cyc(1'b0, 1'b1, 1'b1, 8'h33);  // cycle 0, IDLE: branch ignored
    check("rr_pc_advance", 16'(pc_advance), 16'h0);
    check("rr_pc_control", 16'(pc_control), 16'h0);
    check("rr_jump_offset", 16'(jump_offset), 16'h0);
    check("rr_imem_en", 16'(imem_en), 16'h0);
    check("rr_imem_addr", 16'(imem_addr), 16'h0);
    check("rr_instr", 16'(instr), 16'h0);
    check("rr_instr_pc", 16'(instr_pc), 16'h0);
    check("rr_valid", 16'(instr_valid), 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 8'h10);  // cycle 1
    check("rr1_imem_en", 16'(imem_en), 16'h1);
    check("rr1_imem_addr", 16'(imem_addr), 16'h00);
    check("rr1_pc_control", 16'(pc_control), 16'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'hEB);  // cycle 2, FLUSH, new branch
    check("rr2_pc", 16'(pc), 16'h01);
    check("rr2_pc_control", 16'(pc_control), 16'hFF);
    check("rr2_jump_offset", 16'(jump_offset), 16'h10);
    check("rr2_imem_en", 16'(imem_en), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 3, repeated FLUSH
    check("rr3_pc", 16'(pc), 16'h12);
    check("rr3_pc_control", 16'(pc_control), 16'hFF);
    check("rr3_jump_offset", 16'(jump_offset), 16'hEB);
    check("rr3_valid", 16'(instr_valid), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);  // cycle 4
    check("wrap_imem_en_fe", 16'(imem_en), 16'h1);
    check("wrap_imem_addr_fe", 16'(imem_addr), 16'hFE);
    repeat (PF ? 2 : 4) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("wrap_imem_en_00", 16'(imem_en), 16'h1);
    check("wrap_imem_addr_00", 16'(imem_addr), 16'h00);
    check("wrap_instr_pc_mid", 16'(instr_pc), PF ? 16'hFE : 16'hFF);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("wrap_valid_00", 16'(instr_valid), 16'h1);
    check("wrap_instr_pc_00", 16'(instr_pc), 16'h00);
    check("wrap_instr_00", 16'(instr), 16'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
